pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Sequences the fetch PC register: computes pc_next and pc_enable.
//  Drives IF/ID enable and IF/ID + ID/EX flushes for stalls, redirects and halt.
//  Sits between hazard detection / EX branch resolution and the PC register.
//  Catches out-of-range and misaligned PC targets the PC register would silently refuse.
// PARAMETERS
//  ADDRESS_WIDTH  32   width of all PC/address buses
//  MEM_SIZE       256  instruction memory depth in words; legal pc_next < 4*(MEM_SIZE-1)
//  LOAD_USE_STALL 1    bubble cycles inserted per load-use hazard (1..7)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous reset, active-high
//  pc_current      in   AW  current inst_address from the PC register
//  branch_taken    in   1   EX: conditional branch resolved taken
//  branch_target   in   AW  EX: branch target
//  jump            in   1   ID: unconditional jump decoded
//  jump_target     in   AW  ID: jump target
//  load_use_hazard in   1   ID: load-use dependency detected
//  mem_busy        in   1   data memory not ready; freeze pipeline front
//  halt_req        in   1   halt request (ebreak/ecall/debug)
//  pc_next         out  AW  next PC to the PC register
//  pc_enable       out  1   PC register load enable
//  ifid_enable     out  1   IF/ID register enable
//  ifid_flush      out  1   IF/ID clear to NOP
//  idex_flush      out  1   ID/EX clear to NOP (bubble)
//  halted          out  1   sequencer in HALT
//  fault           out  1   HALT entered due to bad target (sticky until rst)
// BEHAVIOUR
//  - Outputs are combinational from registered state plus inputs; state/counters update on posedge clk.
//  - States: RUN, STALL, HALT.
//  - rst high: next state RUN, stall counter 0, fault 0.
//    Same cycle outputs: pc_next=0, pc_enable=0, ifid_enable=0, ifid_flush=1, idex_flush=1, halted=0.
//  - Candidate target: branch_target if branch_taken, else jump_target if jump, else pc_current+4 (mod 2^AW).
//  - Bad target: target >= 4*(MEM_SIZE-1) or target[1:0]!=0.
//  - Priority, highest first (RUN and STALL):
//    1. halt_req: -> HALT; pc_enable=0, ifid_flush=1, idex_flush=1.
//    2. Bad target: -> HALT; fault<=1; pc_enable=0; same flushes as 1. Applies to sequential overflow too.
//    3. branch_taken: pc_next=branch_target, pc_enable=1, ifid_flush=1, idex_flush=1, ifid_enable=1.
//       Cancels any STALL in progress; -> RUN.
//    4. jump: pc_next=jump_target, pc_enable=1, ifid_flush=1, idex_flush=0.
//       STALL state: jump is ignored until STALL ends.
//    5. mem_busy: pc_enable=0, ifid_enable=0, no flush; state and stall counter frozen.
//    6. RUN & load_use_hazard: pc_enable=0, ifid_enable=0, idex_flush=1.
//       If LOAD_USE_STALL>1: -> STALL, cnt<=LOAD_USE_STALL-1.
//    7. Otherwise: pc_next=pc_current+4, pc_enable=1, ifid_enable=1, no flush.
//  - STALL: per cycle, priorities 1-3/5 apply; else pc_enable=0, ifid_enable=0, idex_flush=1, cnt--.
//    When cnt reaches 1, -> RUN on that edge.
//  - HALT: pc_enable=0, ifid_enable=0, ifid_flush=1, idex_flush=1, halted=1; all inputs ignored.
//    Exit only by rst.
//  - Total load-use bubbles = exactly LOAD_USE_STALL cycles (absent mem_busy/redirect).
// CONFIGURATION
//  PC_SEQ_PERF_EN defined:
//    - adds outputs stall_cycles[31:0] and flush_events[31:0]; both reset to 0, saturate at 2^32-1.
//    - stall_cycles += 1 each cycle pc_enable=0 outside HALT/rst.
//    - flush_events += 1 each accepted redirect (priority 3 or 4).
//  PC_SEQ_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset: rst=1 for 2 cycles with random inputs -> pc_next=0, pc_enable=0, flushes=1.
//    After release, pc_current=0 -> pc_next=4, pc_enable=1.
//  - Load-use, LOAD_USE_STALL=2: hazard 1 cycle at pc_current=0x20 -> 2 cycles pc_enable=0, idex_flush=1.
//    Third cycle: pc_next=0x24.
//  - Branch during STALL: branch_taken, target 0x100 on 1st stall cycle -> pc_next=0x100, pc_enable=1.
//    Both flushes=1; RUN next cycle.
//  - Simultaneous branch 0x40 + jump 0x80 -> pc_next=0x40.
//    With mem_busy=1 and no redirect: pc_enable=0, ifid_enable=0, no flush.
//  - MEM_SIZE=256: pc_current=0x3F8 sequential -> HALT, fault=1, pc_enable=0.
//    Jump to 0x102 -> HALT, fault=1; only rst clears.
//  - PC_SEQ_PERF_EN: 3 stall cycles + 2 redirects -> stall_cycles=3, flush_events=2.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencing for the pipeline front end.
// Chooses the next PC (sequential, jump, branch), inserts load-use
// bubbles, freezes on data-memory back-pressure, and halts on request or
// when the selected target lies outside instruction memory or is misaligned.
// Optional feature macro: PC_SEQ_PERF_EN adds stall_cycles/flush_events
// performance counters.

module pc_sequencer #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MEM_SIZE       = 256,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc_current,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic                     jump,
    input  logic [ADDRESS_WIDTH-1:0] jump_target,
    input  logic                     load_use_hazard,
    input  logic                     mem_busy,
    input  logic                     halt_req,
    output logic [ADDRESS_WIDTH-1:0] pc_next,
    output logic                     pc_enable,
    output logic                     ifid_enable,
    output logic                     ifid_flush,
    output logic                     idex_flush,
    output logic                     halted,
    output logic                     fault
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        HALT
    } state_t;

    // First word address the PC register refuses to load.
    localparam logic [ADDRESS_WIDTH-1:0] PC_LIMIT = ADDRESS_WIDTH'(4 * (MEM_SIZE - 1));
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALL - 1);

    state_t state, nextState;
    logic [2:0] cnt, nextCnt;
    logic setFault;
    logic redirect;
    logic inStall;
    logic badTarget;
    logic [ADDRESS_WIDTH-1:0] seqPc;
    logic [ADDRESS_WIDTH-1:0] target;

    // State, remaining-bubble counter and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
            fault <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (setFault) begin
                fault <= 1'b1;
            end
        end
    end

    // Target selection, priority resolution, next state and all outputs.
    always_comb begin
        seqPc       = pc_current + ADDRESS_WIDTH'(4);
        inStall     = (state == STALL);
        if (branch_taken) begin
            target = branch_target;
        end else if (jump && !inStall) begin
            target = jump_target;
        end else begin
            target = seqPc;
        end
        badTarget   = (target >= PC_LIMIT) || (target[1:0] != 2'b00);

        nextState   = state;
        nextCnt     = cnt;
        setFault    = 1'b0;
        redirect    = 1'b0;
        pc_next     = seqPc;
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        halted      = 1'b0;

        if (rst) begin
            pc_next    = '0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            nextState  = RUN;
            nextCnt    = 3'd0;
        end else if (state == HALT) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b1;
        end else if (halt_req) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            nextState  = HALT;
        end else if (badTarget) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            setFault   = 1'b1;
            nextState  = HALT;
        end else if (branch_taken) begin
            pc_next     = branch_target;
            pc_enable   = 1'b1;
            ifid_enable = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            redirect    = 1'b1;
            nextState   = RUN;
            nextCnt     = 3'd0;
        end else if (jump && !inStall) begin
            pc_next     = jump_target;
            pc_enable   = 1'b1;
            ifid_enable = 1'b1;
            ifid_flush  = 1'b1;
            redirect    = 1'b1;
        end else if (mem_busy) begin
            // Everything frozen: no load, no flush, state and counter held.
            nextState = state;
        end else if (inStall) begin
            idex_flush = 1'b1;
            if (cnt <= 3'd1) begin
                nextState = RUN;
                nextCnt   = 3'd0;
            end else begin
                nextCnt = cnt - 3'd1;
            end
        end else if (load_use_hazard) begin
            idex_flush = 1'b1;
            if (LOAD_USE_STALL > 1) begin
                nextState = STALL;
                nextCnt   = STALL_RELOAD;
            end
        end else begin
            pc_enable   = 1'b1;
            ifid_enable = 1'b1;
        end
    end

`ifdef PC_SEQ_PERF_EN
    // Saturating counters of frozen-PC cycles and accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if ((state != HALT) && !pc_enable && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect && (flush_events != 32'hFFFF_FFFF)) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule
